// File: rtl/breathe_pwm_multi.sv
// Multi-channel breathing PWM: a triangle index squared into a duty cycle, refreshed once per PWM frame.
// Optional macro BREATHE_PHASE_EN staggers the channels' indices evenly across the breathing period.
module breathe_pwm_multi #(
   parameter int CHANNELS  = 4,
   parameter int PWM_WIDTH = 6,
   parameter int STEP_W    = 6,
   parameter int PRESCALE  = 2
) (
   input  logic                sysclk,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Stop,
   input  logic                Mode,
   input  logic [CHANNELS-1:0] Enable,
   output logic [CHANNELS-1:0] Pulse,
   output logic                Busy,
   output logic                Period_Done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SQ_W  = 2 * (STEP_W - 1);
   localparam int SHIFT = SQ_W - PWM_WIDTH;
   localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [STEP_W-1:0] IDX_ONE = STEP_W'(1);
`ifdef BREATHE_PHASE_EN
   localparam int PHASE_STEP = (2 ** STEP_W) / CHANNELS;
`endif

   function automatic logic [PWM_WIDTH-1:0] duty_of(input logic [STEP_W-1:0] idx);
      logic [STEP_W-2:0] tri_v;
      logic [SQ_W-1:0]   sq_v;
      tri_v = idx[STEP_W-1] ? ~idx[STEP_W-2:0] : idx[STEP_W-2:0];
      sq_v  = SQ_W'(tri_v) * SQ_W'(tri_v);
      return PWM_WIDTH'(sq_v >> SHIFT);
   endfunction

   logic [0:0]                         state_q, state_d;
   logic                               mode_q, mode_d;
   logic [PS_W-1:0]                    presc_q, presc_d;
   logic [PWM_WIDTH-1:0]               cnt_q, cnt_d;
   logic [STEP_W-1:0]                  idx_q, idx_d;
   logic [CHANNELS-1:0][PWM_WIDTH-1:0] duty_q, duty_d;

   logic                               tick_s, cnt_wrap_s, period_end_s, busy_s;
   logic [STEP_W-1:0]                  idx_next_s, load_idx_s;
   logic [CHANNELS-1:0][PWM_WIDTH-1:0] duty_new_s;
   logic [CHANNELS-1:0]                pulse_s;

   // Frame timing strobes and the duty values that would be loaded at the next frame boundary.
   always_comb begin
      tick_s       = (state_q == ST_RUN) && (presc_q == PS_LAST);
      cnt_wrap_s   = tick_s && (cnt_q == '1);
      period_end_s = cnt_wrap_s && (idx_q == '1);
      idx_next_s   = idx_q + IDX_ONE;
      // Start loads the frame-0 duty; a running frame wrap loads the duty for the new index.
      load_idx_s   = (state_q == ST_IDLE) ? '0 : idx_next_s;
      for (int c = 0; c < CHANNELS; c++) begin
`ifdef BREATHE_PHASE_EN
         duty_new_s[c] = duty_of(load_idx_s + STEP_W'(c * PHASE_STEP));
`else
         duty_new_s[c] = duty_of(load_idx_s);
`endif
      end
   end

   // Next-state logic: IDLE holds everything cleared, RUN advances prescaler/counter/index.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      duty_d  = duty_q;
      if (state_q == ST_IDLE) begin
         if (Start && !Stop) begin
            state_d = ST_RUN;
            mode_d  = Mode;
            presc_d = '0;
            cnt_d   = '0;
            idx_d   = '0;
            duty_d  = duty_new_s;
         end else begin
            presc_d = '0;
            cnt_d   = '0;
            idx_d   = '0;
            duty_d  = '0;
         end
      end else if (Stop || (period_end_s && mode_q)) begin
         state_d = ST_IDLE;
         presc_d = '0;
         cnt_d   = '0;
         idx_d   = '0;
         duty_d  = '0;
      end else begin
         presc_d = tick_s ? '0 : presc_q + PS_W'(1);
         if (tick_s) begin
            cnt_d = cnt_q + PWM_WIDTH'(1);
         end else begin
            cnt_d = cnt_q;
         end
         if (cnt_wrap_s) begin
            idx_d  = idx_next_s;
            duty_d = duty_new_s;
         end else begin
            idx_d  = idx_q;
            duty_d = duty_q;
         end
      end
   end

   // State registers with synchronous reset taking priority over every request.
   always_ff @(posedge sysclk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         presc_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         duty_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         duty_q  <= duty_d;
      end
   end

   // Outputs decode straight from registers so PWM edges carry no extra latency.
   always_comb begin
      busy_s = (state_q == ST_RUN);
      for (int c = 0; c < CHANNELS; c++) begin
         pulse_s[c] = busy_s && Enable[c] && (cnt_q < duty_q[c]);
      end
   end

   assign Pulse       = pulse_s;
   assign Busy        = busy_s;
   assign Period_Done = period_end_s;

endmodule

// File: tb/tb_breathe_pwm_multi.sv
// Scoreboard bench for breathe_pwm_multi (default build): expectations are queued by cycle number,
// a negedge monitor pops and compares them; Period_Done pulses are matched against a separate queue.
module tb_breathe_pwm_multi;

   logic       sysclk = 1'b0;
   logic       Reset, Start, Stop, Mode;
   logic [3:0] Enable;
   logic [3:0] Pulse;
   logic       Busy, Period_Done;

   typedef struct {
      int         cyc;
      logic [3:0] pulse;
      logic       busy;
      logic       pd;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    pd_q[$];
   int    cyc_cnt = 0;
   int    n_cmp   = 0;
   int    n_bad   = 0;
   exp_t  mon_e;
   string mon_tag;

   breathe_pwm_multi dut (
      .sysclk      (sysclk),
      .Reset       (Reset),
      .Start       (Start),
      .Stop        (Stop),
      .Mode        (Mode),
      .Enable      (Enable),
      .Pulse       (Pulse),
      .Busy        (Busy),
      .Period_Done (Period_Done)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc_cnt <= cyc_cnt + 1;

   // Monitor: compare every queued expectation due this cycle, and every Period_Done pulse.
   always @(negedge sysclk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
         mon_e   = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         n_cmp   = n_cmp + 1;
         if (mon_e.cyc != cyc_cnt) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_tag, mon_e.cyc, cyc_cnt);
         end else if ({Pulse, Busy, Period_Done} !== {mon_e.pulse, mon_e.busy, mon_e.pd}) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @%0d: got pulse=%h busy=%b pd=%b, want pulse=%h busy=%b pd=%b",
                     mon_tag, cyc_cnt, Pulse, Busy, Period_Done, mon_e.pulse, mon_e.busy, mon_e.pd);
         end
      end
      if (Period_Done !== 1'b0) begin
         n_cmp = n_cmp + 1;
         if (pd_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL pd_event: unexpected Period_Done=%b at cycle %0d", Period_Done, cyc_cnt);
         end else begin
            if (pd_q[0] != cyc_cnt) begin
               n_bad = n_bad + 1;
               $display("FAIL pd_event: Period_Done at cycle %0d, want cycle %0d", cyc_cnt, pd_q[0]);
            end
            void'(pd_q.pop_front());
         end
      end
   end

   task automatic push(input int cyc, input logic [3:0] p, input logic b, input logic pd, input string tg);
      exp_t e;
      e.cyc   = cyc;
      e.pulse = p;
      e.busy  = b;
      e.pd    = pd;
      exp_q.push_back(e);
      tag_q.push_back(tg);
      if (pd) pd_q.push_back(cyc);
   endtask

   // One 128-cycle frame at a hand-computed duty: pulse high while pwm_cnt = (t/2)%64 is below it.
   task automatic push_frame(input int s, input int frame, input int duty, input logic [3:0] en, input string tg);
      for (int t = frame * 128; t < frame * 128 + 128; t++) begin
         push(s + t, (((t / 2) % 64) < duty) ? en : 4'h0, 1'b1, 1'b0, tg);
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic goto(input int x);
      while (cyc_cnt < x) step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      Reset  = 1'b1;
      Start  = 1'b0;
      Stop   = 1'b0;
      Mode   = 1'b0;
      Enable = 4'hF;
      step();
      step();
      push(cyc_cnt + 1, 4'h0, 1'b0, 1'b0, "reset_out");
      step();
      Reset = 1'b0;
      step();

      // Run A: continuous, duty 0 in frame 0, duty 16 at index 16, Stop+Start at index 20.
      Mode  = 1'b0;
      Start = 1'b1;
      s     = cyc_cnt + 1;
      push_frame(s, 0, 0, 4'hF, "frame0");
      push_frame(s, 16, 16, 4'hF, "idx16");
      push(s + 2569, 4'hF, 1'b1, 1'b0, "idx20");
      push(s + 2570, 4'h0, 1'b0, 1'b0, "stop_idle");
      for (int k = 2571; k < 2580; k++) push(s + k, 4'h0, 1'b0, 1'b0, "idle_hold");
      step();
      Start = 1'b0;
      goto(s + 2569);
      Stop  = 1'b1;
      Start = 1'b1;
      step();
      Stop  = 1'b0;
      Start = 1'b0;
      goto(s + 2590);

      // Run B: restart from index 0, symmetric peak at 31/32, Reset (with Start) at index 40.
      Start = 1'b1;
      s     = cyc_cnt + 1;
      push_frame(s, 0, 0, 4'hF, "restart0");
      push_frame(s, 31, 60, 4'hF, "idx31");
      push_frame(s, 32, 60, 4'hF, "idx32");
      push(s + 5129, 4'hF, 1'b1, 1'b0, "idx40");
      push(s + 5130, 4'h0, 1'b0, 1'b0, "reset_mid");
      push(s + 5131, 4'h0, 1'b0, 1'b0, "reset_hold");
      step();
      Start = 1'b0;
      goto(s + 5129);
      Reset = 1'b1;
      Start = 1'b1;
      step();
      Reset = 1'b0;
      Start = 1'b0;
      step();
      step();

      // Run C: one-shot with partial enable; a mid-run Start (Mode=0) must be ignored.
      Enable = 4'h5;
      Mode   = 1'b1;
      Start  = 1'b1;
      s      = cyc_cnt + 1;
      push(s, 4'h0, 1'b1, 1'b0, "os_start");
      push_frame(s, 16, 16, 4'h5, "os_idx16");
      push(s + 8191, 4'h0, 1'b1, 1'b1, "os_done");
      push(s + 8192, 4'h0, 1'b0, 1'b0, "os_idle");
      push(s + 8193, 4'h0, 1'b0, 1'b0, "os_idle2");
      step();
      Start = 1'b0;
      Mode  = 1'b0;
      goto(s + 1000);
      Start = 1'b1;
      step();
      Start = 1'b0;
      goto(s + 8200);

      // Run D: Start accepted after one-shot, duty 1 at index 4, then Stop; Start+Stop in IDLE stays idle.
      Enable = 4'hF;
      Start  = 1'b1;
      s      = cyc_cnt + 1;
      push(s, 4'h0, 1'b1, 1'b0, "restart_busy");
      push_frame(s, 4, 1, 4'hF, "idx4");
      push(s + 700, 4'h0, 1'b0, 1'b0, "stop2");
      step();
      Start = 1'b0;
      goto(s + 699);
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      step();
      push(cyc_cnt + 1, 4'h0, 1'b0, 1'b0, "idle_start_stop");
      push(cyc_cnt + 2, 4'h0, 1'b0, 1'b0, "idle_start_stop2");
      Start = 1'b1;
      Stop  = 1'b1;
      step();
      Start = 1'b0;
      Stop  = 1'b0;

      for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
      if (exp_q.size() > 0 || pd_q.size() > 0) begin
         n_bad = n_bad + exp_q.size() + pd_q.size();
         $display("FAIL leftover: %0d expectations and %0d Period_Done pulses never seen",
                  exp_q.size(), pd_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
